// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS main control unit.
// Build option: MIPS_MC_ADDI_EN enables decoding of addi (opcode 001000).
package mips_pkg;

    // Opcode field values (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALUOp encodings seen by the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand selects
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Codes are visible on the debug State port, so they are fixed.
    // ADDI_EX/ADDI_WB keep their codes even when addi is not built;
    // they are then simply unreachable.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_t;

    // Bundle of every datapath control produced by the output decoder
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    // True for opcodes this build knows how to execute
    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
`ifdef MIPS_MC_ADDI_EN
            OP_ADDI: ok = 1'b1;
`else
            OP_ADDI: ok = 1'b0;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_out.sv
// Combinational state-to-control decoder for mips_mc_ctrl.
// Build option: MIPS_MC_ADDI_EN adds the ADDI_EX/ADDI_WB output rows.
// Reset masks every side-effecting strobe so nothing is written to the
// PC, memory or register file while rst is held.
module mips_mc_ctrl_out
    import mips_pkg::*;
(
    input  state_t      state_i,
    input  logic [5:0]  op_i,
    input  logic        mem_ready_i,
    input  logic        rst_i,
    output ctrl_t       ctrl_o
);

    // Moore decode per state, then reset gating of the strobes
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.i_or_d    = 1'b0;
                ctrl_o.alu_src_a = 1'b0;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                // IR and PC update only in the cycle the read completes
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_a  = 1'b0;
                ctrl_o.alu_src_b  = SRCB_IMM_SH;
                ctrl_o.alu_op     = ALUOP_ADD;
                ctrl_o.illegal_op = ~op_supported(op_i);
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_dst    = 1'b0;
            end
            S_MEM_WR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.mem_to_reg = 1'b0;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_REG;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
`ifdef MIPS_MC_ADDI_EN
            S_ADDI_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_ADDI_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b0;
                ctrl_o.mem_to_reg = 1'b0;
            end
`endif
            default: ctrl_o = '0;
        endcase

        if (rst_i) begin
            ctrl_o.pc_write      = 1'b0;
            ctrl_o.pc_write_cond = 1'b0;
            ctrl_o.mem_read      = 1'b0;
            ctrl_o.mem_write     = 1'b0;
            ctrl_o.ir_write      = 1'b0;
            ctrl_o.reg_write     = 1'b0;
            ctrl_o.illegal_op    = 1'b0;
        end
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS main control unit: state register and next-state logic.
// Build option: MIPS_MC_ADDI_EN routes addi through ADDI_EX/ADDI_WB;
// without it addi is treated as an illegal opcode.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 into PC when memory is ready
// DECODE   | read registers, precompute branch target, dispatch on Op
// MEM_ADDR | effective address for lw/sw
// MEM_RD   | data read, hold until MemReady
// MEM_WB   | MDR into rt
// MEM_WR   | data write, hold until MemReady
// EXEC     | R-type ALU operation
// R_WB     | ALUOut into rd
// BRANCH   | compare and conditional PC load
// JUMP     | PC load from jump target
// ADDI_EX  | register + immediate
// ADDI_WB  | ALUOut into rt
module mips_mc_ctrl
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  Op,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic        IllegalOp,
    output logic [3:0]  State
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: memory states hold on MemReady, DECODE dispatches on Op
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MIPS_MC_ADDI_EN
                    OP_ADDI:      state_d = S_ADDI_EX;
`else
                    OP_ADDI:      state_d = S_FETCH;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            // Only lw and sw reach MEM_ADDR, so anything but sw is a load
            S_MEM_ADDR: state_d = (Op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_d = MemReady ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   state_d = MemReady ? S_FETCH : S_MEM_WR;
            S_EXEC:     state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
`ifdef MIPS_MC_ADDI_EN
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_ADDI_WB:  state_d = S_FETCH;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    mips_mc_ctrl_out u_out (
        .state_i     (state_q),
        .op_i        (Op),
        .mem_ready_i (MemReady),
        .rst_i       (rst),
        .ctrl_o      (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign IllegalOp   = ctrl.illegal_op;
    assign State       = state_q;

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multi-cycle MIPS main control unit. It sequences each instruction through fetch, decode, execute, memory and write-back states, and drives the datapath strobes and multiplexer selects. It produces the 2-bit ALUOp consumed by the ALU control decoder: 00 forces add, 01 forces sub, 10 defers to funct. It sits between the instruction register opcode field and the shared memory, register file, PC and ALU datapath.

## Interface
Parameters:
- none.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Op  in  6  opcode, IR[31:26]; valid from DECODE onward.
- MemReady  in  1  memory handshake; the access completes in the cycle it is high.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load when ALU Zero is set.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  register write data select: 0 = ALUOut, 1 = MDR.
- RegDst  out  1  register write address select: 0 = rt, 1 = rd.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate.
- ALUOp  out  2  to the ALU control decoder.
- PCSource  out  2  PC source select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- IllegalOp  out  1  one-cycle pulse on an unsupported opcode.
- State  out  4  current state, for debug.

## Operation
- Moore FSM with a 4-bit state register. Outputs not listed for a state are 0.
- State codes: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite equal MemReady. Go to DECODE when MemReady=1, else hold.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Op:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDI_EX
  - any other opcode -> FETCH, with IllegalOp=1 for this cycle.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: MemRead=1, IorD=1. Go to MEM_WB when MemReady=1, else hold.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Go to FETCH.
- MEM_WR: MemWrite=1, IorD=1. Go to FETCH when MemReady=1, else hold; MemWrite stays high while holding.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Go to FETCH.
- JUMP: PCWrite=1, PCSource=10. Go to FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0. Go to FETCH.
- Unused state codes 12-15 -> FETCH. Outputs in those codes are all 0.

## Timing
- rst asserted: State=FETCH immediately (asynchronous). While rst=1, PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite and IllegalOp are forced to 0. The first FETCH strobes appear in the first cycle after rst deasserts.
- rst mid-instruction: the instruction is abandoned and the FSM restarts at FETCH.
- Cycle counts with MemReady held at 1:
  - beq and j: 3 cycles.
  - R-type, sw and addi: 4 cycles.
  - lw: 5 cycles.
  - Each cycle MemReady is low in FETCH, MEM_RD or MEM_WR adds one cycle.
- Op is sampled only in DECODE and MEM_ADDR. It must be stable from the cycle after IRWrite until the instruction returns to FETCH.
- IllegalOp is high for exactly one cycle, the DECODE cycle.

## Configuration
- MIPS_MC_ADDI_EN defined: addi (Op 001000) is decoded through ADDI_EX and ADDI_WB.
- MIPS_MC_ADDI_EN undefined: ADDI_EX and ADDI_WB are not built. Op 001000 is illegal: DECODE goes to FETCH with IllegalOp=1.

## Structure
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - ALUOp constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10;
  - the state enum typedef and the ALUSrcB/PCSource select constants.
- One sub-module, mips_mc_ctrl_out: a purely combinational state-to-output decoder, including MemReady and rst gating. The parent module holds the state register and next-state logic.

## Test plan
- Reset: rst pulse mid-MEM_RD -> State=0 in the same cycle and all strobes 0. After release, FETCH shows MemRead=1, ALUSrcB=01.
- lw, Op=100011, MemReady=1 -> States 0,1,2,3,4. RegWrite=1 and MemtoReg=1 only in state 4. ALUOp=00 throughout.
- R-type, Op=000000 -> States 0,1,6,7. ALUOp=10 in state 6. RegWrite=1 and RegDst=1 in state 7.
- beq, Op=000100 -> State 8 with ALUOp=01, PCWriteCond=1, PCSource=01. FETCH follows.
- MemReady stall: sw with MemReady low for 2 cycles in MEM_WR -> MemWrite held high for 3 cycles, then FETCH.
- Op=111111 -> IllegalOp=1 for one cycle in DECODE, then FETCH. With MIPS_MC_ADDI_EN undefined, Op=001000 behaves the same.
